// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard receiver folding E0/F0 prefixes into a 10-bit scancode
// Optional macro PS2_RX_ERR_INHIBIT_EN holds ps2_clk low for INHIBIT_CYCLES after any rx_error.
module ps2_scan_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int INHIBIT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        ps2_clk,
   inout  wire        ps2_dat,
   output logic       code_ready,
   output logic [9:0] scancode,
   output logic       rx_error
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt, dat_filt, clk_filt_d;
   logic [FW-1:0] clk_cnt, dat_cnt;
   logic          inhibit;
   logic          fall;

   state_t        state, state_n;
   logic [7:0]    shift_q, shift_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic          par_q, par_n;
   logic          ext_q, ext_n, brk_q, brk_n;
   logic [TW-1:0] to_cnt, to_n;
   logic [9:0]    code_n;
   logic          ready_n, err_n;
   logic          frame_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end
   end

   // A filtered line only moves after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_filt   <= 1'b1;
         dat_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         clk_cnt    <= '0;
         dat_cnt    <= '0;
      end else begin
         clk_filt_d <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FILT_LAST) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + FW'(1);
         end
         if (dat_sync[1] == dat_filt) begin
            dat_cnt <= '0;
         end else if (dat_cnt == FILT_LAST) begin
            dat_filt <= dat_sync[1];
            dat_cnt  <= '0;
         end else begin
            dat_cnt <= dat_cnt + FW'(1);
         end
      end
   end

`ifdef PS2_RX_ERR_INHIBIT_EN
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   logic [IW-1:0] inh_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inhibit <= 1'b0;
         inh_cnt <= '0;
      end else if (rx_error) begin
         inhibit <= 1'b1;
         inh_cnt <= '0;
      end else if (inhibit) begin
         if (inh_cnt == INH_LAST) inhibit <= 1'b0;
         else                     inh_cnt <= inh_cnt + IW'(1);
      end
   end

   assign ps2_clk = inhibit ? 1'b0 : 1'bz;
`else
   logic [31:0] unused_inhibit_cycles;
   assign unused_inhibit_cycles = INHIBIT_CYCLES;
   assign inhibit = 1'b0;
   assign ps2_clk = 1'bz;
`endif
   assign ps2_dat = 1'bz;

   // Our own inhibit pulls the clock low; that edge must not be taken as a start bit.
   assign fall = clk_filt_d & ~clk_filt & ~inhibit;

   always_comb begin
      state_n   = state;
      shift_n   = shift_q;
      bit_cnt_n = bit_cnt;
      par_n     = par_q;
      ext_n     = ext_q;
      brk_n     = brk_q;
      code_n    = scancode;
      ready_n   = 1'b0;
      err_n     = 1'b0;
      frame_ok  = dat_filt & (^{shift_q, par_q});
      to_n      = (state == IDLE || fall) ? '0 : to_cnt + TW'(1);

      case (state)
         IDLE: begin
            if (fall && !dat_filt) begin
               state_n   = DATA;
               bit_cnt_n = 3'd0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_n   = {dat_filt, shift_q[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_n   = dat_filt;
               state_n = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_n = IDLE;
               if (!frame_ok) begin
                  err_n = 1'b1;
                  ext_n = 1'b0;
                  brk_n = 1'b0;
               end else if (shift_q == 8'hE0) begin
                  ext_n = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  brk_n = 1'b1;
               end else begin
                  code_n  = {ext_q, brk_q, shift_q};
                  ready_n = 1'b1;
                  ext_n   = 1'b0;
                  brk_n   = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A real edge in the same cycle always beats the timeout.
      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
         state_n = IDLE;
         err_n   = 1'b1;
         ext_n   = 1'b0;
         brk_n   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         par_q      <= 1'b0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         to_cnt     <= '0;
         scancode   <= '0;
         code_ready <= 1'b0;
         rx_error   <= 1'b0;
      end else begin
         state      <= state_n;
         shift_q    <= shift_n;
         bit_cnt    <= bit_cnt_n;
         par_q      <= par_n;
         ext_q      <= ext_n;
         brk_q      <= brk_n;
         to_cnt     <= to_n;
         scancode   <= code_n;
         code_ready <= ready_n;
         rx_error   <= err_n;
      end
   end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, clk cycles a raw PS/2 line must stay stable before its filtered value changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, maximum clk cycles between filtered ps2_clk falling edges inside a frame.
REQ-003 Parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low after an error (REQ-024 only).
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  inout  1  PS/2 clock line, open-drain.
REQ-007 ps2_dat  inout  1  PS/2 data line, open-drain, never driven by this block.
REQ-008 code_ready  output  1  one-cycle pulse marking a new scancode.
REQ-009 scancode  output  10  {ext, brk, byte[7:0]}: bit 9 means an E0 prefix was seen, bit 8 means an F0 (break) prefix was seen.
REQ-010 rx_error  output  1  one-cycle pulse on a frame error or a timeout.

Function
REQ-011 Each PS/2 line shall pass through a 2-flop synchronizer and then a stability filter; the filtered value shall update only after FILTER_LEN consecutive identical synchronized samples.
REQ-012 Only a filtered ps2_clk high-to-low transition shall sample filtered ps2_dat.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
- IDLE to DATA on a sampled 0 (start bit); a sampled 1 in IDLE shall be ignored.
- DATA shifts 8 bits LSB first, then moves to PARITY.
- PARITY to STOP.
- STOP to IDLE.
REQ-014 A frame is valid when the start bit is 0, data plus parity has odd parity, and the stop bit is 1.
REQ-015 Valid byte 0xE0 shall set the ext flag; valid byte 0xF0 shall set the brk flag; neither shall pulse code_ready.
REQ-016 Any other valid byte shall load scancode={ext,brk,byte}, pulse code_ready for exactly one clk cycle in the cycle after the stop bit is sampled, then clear both flags.
REQ-017 scancode shall hold its value between code_ready pulses.
REQ-018 A frame with bad parity or a 0 stop bit shall pulse rx_error, clear both flags, discard the byte, and return to IDLE.
REQ-019 The timeout counter shall clear on every filtered falling edge and in IDLE. On reaching TIMEOUT_CYCLES outside IDLE: pulse rx_error, clear both flags, go to IDLE.
REQ-020 code_ready and rx_error shall never assert in the same cycle.
REQ-021 Bytes 0xE1, 0xAA and 0xFA shall be treated as ordinary codes.
REQ-022 Without REQ-024, ps2_clk and ps2_dat shall always be high-Z.

Reset
REQ-023 While reset is high: state=IDLE, shift register, bit counter, timeout counter and flags cleared; scancode=0, code_ready=0, rx_error=0; filters preset to 1; both lines high-Z. A frame in progress is dropped with no error pulse.

Configuration
REQ-024 Macro PS2_RX_ERR_INHIBIT_EN.
- Defined: after any rx_error, ps2_clk shall be driven 0 for INHIBIT_CYCLES clk cycles and then released. During that time the FSM stays in IDLE and ignores the lines, which forces the keyboard to retransmit.
- Undefined: no inhibit logic; REQ-022 applies.

Verification
REQ-025 Frame 0x1C, parity 0, stop 1 -> one code_ready pulse, scancode=0x01C, rx_error stays 0.
REQ-026 Frames F0,1C -> exactly one code_ready pulse, scancode=0x11C; frames E0,F0,75 -> one pulse, scancode=0x375.
REQ-027 Frames E0, then 0x1C with parity 1, then 75 -> one rx_error pulse, then scancode=0x075 (ext cleared by the error).
REQ-028 ps2_clk stops after 4 data bits -> rx_error pulses TIMEOUT_CYCLES cycles after the last edge; a following frame 0x29 -> scancode=0x029.
REQ-029 ps2_clk low glitch of FILTER_LEN-2 cycles while IDLE with ps2_dat=0 -> no state change and no pulse.
REQ-030 With PS2_RX_ERR_INHIBIT_EN: bad stop bit -> rx_error, then ps2_clk=0 for exactly INHIBIT_CYCLES cycles, then high-Z; the next valid frame decodes normally.
